// File: rtl/pwm_btn_pkg.sv
// Shared types and default timing for the PWM push-button conditioner.
package pwm_btn_pkg;

  // Hold-to-repeat state of one button channel.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY  = 64;
  localparam int DEF_REPEAT_PERIOD = 32;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/pwm_btn_channel.sv
// One button channel: 2-flop synchroniser, stable-count debounce,
// rising-edge detect and hold-to-repeat pulse request FSM.
module pwm_btn_channel
  import pwm_btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic repeat_en,
  input  logic conflict,
  output logic level,
  output logic level_nxt,
  output logic pulse_req
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_d;
  logic             rise;
  rpt_state_e       state;
  rpt_state_e       state_nxt;
  logic [CNT_W-1:0] rcnt;
  logic [CNT_W-1:0] rcnt_nxt;

  // Stage p0/p1: bring the raw pad into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: level follows the synchronised input only after it has
  // disagreed for STABLE_CYCLES consecutive cycles.
  always_comb begin
    level_nxt = level;
    cnt_nxt   = '0;
    if (sync_p1 != level) begin
      if (cnt == STABLE_LAST) begin
        level_nxt = sync_p1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // Debounced level register plus its delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level   <= 1'b0;
      cnt     <= '0;
      level_d <= 1'b0;
    end else begin
      level   <= level_nxt;
      cnt     <= cnt_nxt;
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;

  // Repeat FSM state and its interval counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // Repeat FSM: first pulse on an uncontested rise, then delayed and periodic
  // repeats while the button stays held; any abort condition wins over a pulse.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    pulse_req = 1'b0;
    case (state)
      IDLE: begin
        if (rise && !conflict) begin
          pulse_req = 1'b1;
          if (repeat_en) begin
            state_nxt = DELAY;
            rcnt_nxt  = '0;
          end
        end
      end
      DELAY: begin
        if (!level || !repeat_en || conflict) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt == DELAY_LAST) begin
          pulse_req = 1'b1;
          rcnt_nxt  = '0;
          state_nxt = REPEAT;
        end else begin
          rcnt_nxt = rcnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!level || !repeat_en || conflict) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt == PERIOD_LAST) begin
          pulse_req = 1'b1;
          rcnt_nxt  = '0;
        end else begin
          rcnt_nxt = rcnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        rcnt_nxt  = '0;
      end
    endcase
  end

endmodule

// File: rtl/pwm_btn_conditioner.sv
// Two-button front end for the PWM duty controls: per-channel conditioning,
// simultaneous-press conflict detection and registered one-cycle pulses.
module pwm_btn_conditioner
  import pwm_btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_inc_i,
  input  logic btn_dec_i,
  input  logic repeat_en_i,
  output logic inc_pulse_o,
  output logic dec_pulse_o,
  output logic inc_level_o,
  output logic dec_level_o,
  output logic conflict_o
);

  logic inc_level_nxt;
  logic dec_level_nxt;
  logic inc_req;
  logic dec_req;

  pwm_btn_channel #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CNT_W        (CNT_W)
  ) u_inc (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn_inc_i),
    .repeat_en(repeat_en_i),
    .conflict (conflict_o),
    .level    (inc_level_o),
    .level_nxt(inc_level_nxt),
    .pulse_req(inc_req)
  );

  pwm_btn_channel #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CNT_W        (CNT_W)
  ) u_dec (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn_dec_i),
    .repeat_en(repeat_en_i),
    .conflict (conflict_o),
    .level    (dec_level_o),
    .level_nxt(dec_level_nxt),
    .pulse_req(dec_req)
  );

  // Output stage: conflict is built from the next levels so it changes on
  // the same edge as the levels; pulses are masked by conflict and inc has
  // priority so the two outputs can never coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_o  <= 1'b0;
      inc_pulse_o <= 1'b0;
      dec_pulse_o <= 1'b0;
    end else begin
      conflict_o  <= inc_level_nxt & dec_level_nxt;
      inc_pulse_o <= inc_req & ~conflict_o;
      dec_pulse_o <= dec_req & ~conflict_o & ~inc_req;
    end
  end

endmodule

// File: tb/tb_pwm_btn_conditioner.sv
// Randomised and directed bench for pwm_btn_conditioner with a
// timestamp/window based reference model of the button behaviour.
module tb_pwm_btn_conditioner;

  localparam int STB = 4;
  localparam int RD  = 8;
  localparam int RP  = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_inc_i;
  logic btn_dec_i;
  logic repeat_en_i;
  logic inc_pulse_o;
  logic dec_pulse_o;
  logic inc_level_o;
  logic dec_level_o;
  logic conflict_o;

  int checks = 0;
  int passed = 0;

  pwm_btn_conditioner #(
    .STABLE_CYCLES(STB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_inc_i  (btn_inc_i),
    .btn_dec_i  (btn_dec_i),
    .repeat_en_i(repeat_en_i),
    .inc_pulse_o(inc_pulse_o),
    .dec_pulse_o(dec_pulse_o),
    .inc_level_o(inc_level_o),
    .dec_level_o(dec_level_o),
    .conflict_o (conflict_o)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples per edge since reset, level from a sliding
  // window of synchronised samples, pulses from press timestamps.
  bit   q_inc[$];
  bit   q_dec[$];
  logic m_lvl[2];
  logic m_lvl_prev[2];
  logic m_pulse[2];
  logic m_chain[2];
  logic m_conf;
  int   m_due[2];
  int   m_last_chg[2];
  int   m_n;

  task automatic model_reset();
    q_inc.delete();
    q_dec.delete();
    for (int c = 0; c < 2; c++) begin
      m_lvl[c]      = 1'b0;
      m_lvl_prev[c] = 1'b0;
      m_pulse[c]    = 1'b0;
      m_chain[c]    = 1'b0;
      m_due[c]      = 0;
      m_last_chg[c] = -100;
    end
    m_conf = 1'b0;
    m_n    = 0;
  endtask

  // Synchronised value seen by the debouncer at edge e (two edges of delay).
  function automatic bit obs_at(int c, int e);
    if (e < 2) return 1'b0;
    if (c == 0) return q_inc[e-2];
    return q_dec[e-2];
  endfunction

  task automatic model_step(input bit rin, input bit rdn, input bit ren);
    logic nl[2];
    logic np[2];
    bit   chg;
    q_inc.push_back(rin);
    q_dec.push_back(rdn);
    for (int c = 0; c < 2; c++) begin
      chg = (m_n - STB >= m_last_chg[c]);
      for (int j = 0; j < STB; j++)
        if (obs_at(c, m_n - j) == m_lvl[c]) chg = 1'b0;
      nl[c] = chg ? ~m_lvl[c] : m_lvl[c];
      if (chg) m_last_chg[c] = m_n;
      np[c] = 1'b0;
      if (m_lvl[c] && !m_lvl_prev[c] && !m_conf) begin
        np[c]      = 1'b1;
        m_chain[c] = ren;
        m_due[c]   = m_n + RD;
      end else if (m_chain[c]) begin
        if (!m_lvl[c] || !ren || m_conf) m_chain[c] = 1'b0;
        else if (m_n == m_due[c]) begin
          np[c]    = 1'b1;
          m_due[c] = m_due[c] + RP;
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      m_lvl_prev[c] = m_lvl[c];
      m_lvl[c]      = nl[c];
      m_pulse[c]    = np[c];
    end
    m_conf = nl[0] & nl[1];
    m_n    = m_n + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(btn_inc_i, btn_dec_i, repeat_en_i);
    #1;
  endtask

  task automatic do_reset();
    btn_inc_i   = 1'b0;
    btn_dec_i   = 1'b0;
    repeat_en_i = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [4:0] got;
    reset = 1'b1;
    btn_inc_i = 1'b1;
    btn_dec_i = 1'b1;
    repeat_en_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {inc_pulse_o, dec_pulse_o, inc_level_o, dec_level_o, conflict_o};
    checks++;
    if (got !== 5'b0) $display("FAIL reset_state: got %b want 00000", got);
    else passed++;
    do_reset();
  endtask

  task automatic test_clean_press();
    logic [4:0] got, want;
    int pulses = 0, pulse_edge = -1, lvl_edge = -1, dec_seen = 0;
    do_reset();
    btn_inc_i = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (i == 20) btn_inc_i = 1'b0;
      tick();
      got  = {inc_pulse_o, dec_pulse_o, inc_level_o, dec_level_o, conflict_o};
      want = {m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1], m_conf};
      checks++;
      if (got !== want) $display("FAIL clean_press edge %0d: got %b want %b", i, got, want);
      else passed++;
      if (inc_pulse_o) begin pulses++; if (pulse_edge < 0) pulse_edge = i; end
      if (inc_level_o && lvl_edge < 0) lvl_edge = i;
      if (dec_pulse_o) dec_seen++;
    end
    checks++;
    if (lvl_edge !== 5) $display("FAIL clean_level_edge: got %0d want 5", lvl_edge);
    else passed++;
    checks++;
    if (pulses !== 1 || pulse_edge !== 6)
      $display("FAIL clean_pulse: got count %0d edge %0d want count 1 edge 6", pulses, pulse_edge);
    else passed++;
    checks++;
    if (dec_seen !== 0) $display("FAIL clean_no_dec: got %0d want 0", dec_seen);
    else passed++;
  endtask

  task automatic test_bounce();
    logic [4:0] got, want;
    bit pat[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int pulses = 0, pulse_edge = -1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      btn_dec_i = (i < 8) ? pat[i] : (i < 24);
      tick();
      got  = {inc_pulse_o, dec_pulse_o, inc_level_o, dec_level_o, conflict_o};
      want = {m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1], m_conf};
      checks++;
      if (got !== want) $display("FAIL bounce edge %0d: got %b want %b", i, got, want);
      else passed++;
      if (dec_pulse_o) begin pulses++; if (pulse_edge < 0) pulse_edge = i; end
    end
    checks++;
    if (pulses !== 1 || pulse_edge !== 14)
      $display("FAIL bounce_pulse: got count %0d edge %0d want count 1 edge 14", pulses, pulse_edge);
    else passed++;
  endtask

  task automatic test_repeat();
    logic [4:0] got, want;
    int pulses = 0;
    int pe[3] = '{-1, -1, -1};
    do_reset();
    repeat_en_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      btn_inc_i = (i < 40);
      tick();
      got  = {inc_pulse_o, dec_pulse_o, inc_level_o, dec_level_o, conflict_o};
      want = {m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1], m_conf};
      checks++;
      if (got !== want) $display("FAIL repeat edge %0d: got %b want %b", i, got, want);
      else passed++;
      if (inc_pulse_o) begin
        if (pulses < 3) pe[pulses] = i;
        pulses++;
      end
    end
    checks++;
    if (pulses !== 9) $display("FAIL repeat_count: got %0d want 9", pulses);
    else passed++;
    checks++;
    if (pe[0] !== 6 || pe[1] !== 14 || pe[2] !== 18)
      $display("FAIL repeat_times: got %0d %0d %0d want 6 14 18", pe[0], pe[1], pe[2]);
    else passed++;
  endtask

  task automatic test_conflict();
    logic [4:0] got, want;
    int conf_edge = -1, early = 0, late = 0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      btn_inc_i = (i < 30) || (i >= 40 && i < 52);
      btn_dec_i = (i < 15);
      tick();
      got  = {inc_pulse_o, dec_pulse_o, inc_level_o, dec_level_o, conflict_o};
      want = {m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1], m_conf};
      checks++;
      if (got !== want) $display("FAIL conflict edge %0d: got %b want %b", i, got, want);
      else passed++;
      if (conflict_o && conf_edge < 0) conf_edge = i;
      if (inc_pulse_o || dec_pulse_o) begin
        if (i < 40) early++; else late++;
      end
    end
    checks++;
    if (conf_edge !== 5) $display("FAIL conflict_edge: got %0d want 5", conf_edge);
    else passed++;
    checks++;
    if (early !== 0) $display("FAIL conflict_suppress: got %0d pulses want 0", early);
    else passed++;
    checks++;
    if (late !== 1) $display("FAIL conflict_repress: got %0d pulses want 1", late);
    else passed++;
  endtask

  task automatic test_reset_mid_repeat();
    logic [4:0] got, want;
    int pe[2] = '{-1, -1};
    int pulses = 0;
    do_reset();
    repeat_en_i = 1'b1;
    btn_inc_i   = 1'b1;
    repeat (22) tick();
    #3;
    reset = 1'b1;
    #1;
    got = {inc_pulse_o, dec_pulse_o, inc_level_o, dec_level_o, conflict_o};
    checks++;
    if (got !== 5'b0) $display("FAIL reset_async: got %b want 00000", got);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 24; i++) begin
      tick();
      got  = {inc_pulse_o, dec_pulse_o, inc_level_o, dec_level_o, conflict_o};
      want = {m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1], m_conf};
      checks++;
      if (got !== want) $display("FAIL reset_resume edge %0d: got %b want %b", i, got, want);
      else passed++;
      if (inc_pulse_o) begin
        if (pulses < 2) pe[pulses] = i;
        pulses++;
      end
    end
    checks++;
    if (pe[0] !== 6 || pe[1] !== 14)
      $display("FAIL reset_resume_times: got %0d %0d want 6 14", pe[0], pe[1]);
    else passed++;
  endtask

  task automatic test_glitch();
    logic [4:0] got, want;
    int seen = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      btn_inc_i = (i < 3);
      tick();
      got  = {inc_pulse_o, dec_pulse_o, inc_level_o, dec_level_o, conflict_o};
      want = {m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1], m_conf};
      checks++;
      if (got !== want) $display("FAIL glitch edge %0d: got %b want %b", i, got, want);
      else passed++;
      if (inc_level_o || inc_pulse_o) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL glitch_filtered: got %0d active cycles want 0", seen);
    else passed++;
  endtask

  task automatic test_random();
    logic [4:0] got, want;
    int mode, len;
    bit ni, nd;
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      mode = $urandom_range(0, 3);
      len  = $urandom_range(1, 30);
      ni   = mode[0];
      nd   = mode[1];
      repeat_en_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < len; k++) begin
        btn_inc_i = ni ^ ($urandom_range(0, 7) == 0);
        btn_dec_i = nd ^ ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 31) == 0) repeat_en_i = ~repeat_en_i;
        tick();
        got  = {inc_pulse_o, dec_pulse_o, inc_level_o, dec_level_o, conflict_o};
        want = {m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1], m_conf};
        checks++;
        if (got !== want) $display("FAIL random edge %0d: got %b want %b", m_n - 1, got, want);
        else passed++;
        checks++;
        if (inc_pulse_o && dec_pulse_o)
          $display("FAIL random_exclusive edge %0d: got both pulses want at most one", m_n - 1);
        else passed++;
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    btn_inc_i   = 1'b0;
    btn_dec_i   = 1'b0;
    repeat_en_i = 1'b0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_conflict();
    test_reset_mid_repeat();
    test_glitch();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
